// File: rtl/cdc_word_sender_if.sv
`default_nettype none
// ============================================================================
// cdc_word_sender_if : producer valid/ready bus plus far-domain toggle handshake
// Revision: 1.0
// ============================================================================
interface cdc_word_sender_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_req;
  logic             xfer_ack;
  logic             busy;

  // Environment side: producer plus far-domain receiver
  modport master (
    output in_valid, in_data, xfer_ack,
    input  in_ready, xfer_data, xfer_req, busy
  );

  // Sender side
  modport slave (
    input  in_valid, in_data, xfer_ack,
    output in_ready, xfer_data, xfer_req, busy
  );
endinterface

`default_nettype wire

// File: rtl/cdc_word_sender.sv
`default_nettype none
// ============================================================================
// cdc_word_sender : source side of a toggle-handshake word transfer across a
//                   clock-domain boundary. Optional one-entry skid register
//                   enabled by defining CDC_WORD_SENDER_SKID_EN.
// Revision: 1.0
// ============================================================================
module cdc_word_sender #(
  parameter int WIDTH       = 8,
  parameter int EXTRA_DEPTH = 0
) (
  input  wire logic        clk,
  input  wire logic        reset,
  cdc_word_sender_if.slave bus
);

  localparam int DEPTH = 2 + EXTRA_DEPTH;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DEPTH-1:0] ack_chain;
  logic             ack_sync;
  logic             ack_match;
  logic             req;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             accept;
  logic             launch;
  logic [WIDTH-1:0] launch_data;

  assign ack_sync  = ack_chain[DEPTH-1];
  assign ack_match = (ack_sync == req);
  assign accept    = bus.in_valid && ready;

  // Only the synchronised ack feeds any output, so xfer_ack has no comb path out
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_chain <= '0;
    end else begin
      ack_chain <= {ack_chain[DEPTH-2:0], bus.xfer_ack};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef CDC_WORD_SENDER_SKID_EN
  logic             skid_full;
  logic [WIDTH-1:0] skid;
  logic             skid_load;
  logic             skid_clear;

  assign ready = (state == IDLE) ? ack_match : !skid_full;

  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    launch_data = bus.in_data;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          launch     = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match) begin
          // A waiting word goes straight out; an empty skid lets a fresh word bypass it
          if (skid_full) begin
            launch      = 1'b1;
            launch_data = skid;
            skid_clear  = 1'b1;
          end else if (accept) begin
            launch = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (accept) begin
          skid_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_full <= 1'b0;
      skid      <= '0;
    end else if (skid_load) begin
      skid_full <= 1'b1;
      skid      <= bus.in_data;
    end else if (skid_clear) begin
      skid_full <= 1'b0;
    end
  end
`else
  assign ready = (state == IDLE) && ack_match;

  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    launch_data = bus.in_data;
    case (state)
      IDLE: begin
        if (accept) begin
          launch     = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
`endif

  // Data and request move together so the far side never samples a changing word
  always_ff @(posedge clk) begin
    if (reset) begin
      req  <= 1'b0;
      data <= '0;
    end else if (launch) begin
      req  <= ~req;
      data <= launch_data;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.xfer_req  = req;
  assign bus.xfer_data = data;
  assign bus.busy      = (state == WAIT_ACK);

endmodule

`default_nettype wire
